// File: rtl/vcve2_pkg.sv
// Shared types for the vector register file sequencer.
// Holds the LMUL encoding and the sequencer state type.
package vcve2_pkg;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        VRF_IDLE,
        VRF_LOAD,
        VRF_REQ,
        VRF_WAIT,
        VRF_PRESENT,
        VRF_WRITE,
        VRF_WWAIT
    } vrf_seq_state_t;

endpackage

// File: rtl/vcve2_vrf_beat_counter.sv
// Beat counter: loads the LMUL-scaled beat count, clamped to one,
// and counts beats down; flags reserved LMUL encodings.
module vcve2_vrf_beat_counter
    import vcve2_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int PIPE_WIDTH = 32,
    parameter int CNT_W      = 6
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   dec_i,
    input  vlmul_e lmul_i,
    output logic   last_o,
    output logic   reserved_o
);

    localparam int BASE = VLEN / PIPE_WIDTH;

    logic [CNT_W-1:0] beats;
    logic [CNT_W-1:0] cnt_q;

    // Scale the per-register beat count by LMUL; fractional groups never go below one beat.
    always_comb begin
        beats      = CNT_W'(BASE);
        reserved_o = 1'b0;
        unique case (lmul_i)
            LMUL_1:    beats = CNT_W'(BASE);
            LMUL_2:    beats = CNT_W'(BASE) << 1;
            LMUL_4:    beats = CNT_W'(BASE) << 2;
            LMUL_8:    beats = CNT_W'(BASE) << 3;
            LMUL_F2:   beats = CNT_W'(BASE) >> 1;
            LMUL_F4:   beats = CNT_W'(BASE) >> 2;
            LMUL_F8:   beats = CNT_W'(BASE) >> 3;
            LMUL_RSVD: reserved_o = 1'b1;
        endcase
        if (beats == '0) begin
            beats = CNT_W'(1);
        end
    end

    // Remaining-beat register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= beats;
        end else if (dec_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/vcve2_vrf_sequencer.sv
// VRF sequencer: per beat reads the selected source operands, presents
// them to the pipeline, and optionally writes the result beat back.
module vcve2_vrf_sequencer
    import vcve2_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int PIPE_WIDTH = 32,
    parameter int NUM_SRC    = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    input  logic [NUM_SRC:0]              sel_operation_i,
    input  vlmul_e                        lmul_i,
    output logic                          busy_o,
    output logic [NUM_SRC*PIPE_WIDTH-1:0] rdata_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    input  logic [PIPE_WIDTH-1:0]         wdata_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    output logic                          data_req_o,
    output logic                          data_we_o,
    input  logic                          data_gnt_i,
    input  logic                          data_rvalid_i,
    input  logic                          data_err_i,
    input  logic                          data_pmp_err_i,
    output logic [PIPE_WIDTH/8-1:0]       data_be_o,
    output logic [PIPE_WIDTH-1:0]         data_wdata_o,
    input  logic [PIPE_WIDTH-1:0]         data_rdata_i,
    output logic                          agu_load_o,
    output logic [NUM_SRC:0]              agu_get_o,
    input  logic                          agu_ready_i,
    output logic                          vector_done_o,
    output logic                          err_o
);

    localparam int CNT_W = $clog2(VLEN / PIPE_WIDTH * 8) + 1;
    localparam int SW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    vrf_seq_state_t state_q, state_d;
    logic [NUM_SRC:0] sel_q, sel_d;
    logic [SW-1:0] src_q, src_d, first_src, next_src;
    logic has_src, has_next;
    logic wgnt_q, wgnt_d;
    logic [NUM_SRC*PIPE_WIDTH-1:0] rdata_q;
    logic [PIPE_WIDTH-1:0] wdata_q;
    logic cnt_load, cnt_dec, cnt_last, lmul_rsvd;
    logic cap_en, wcap, beat_end, mem_err;

    vcve2_vrf_beat_counter #(
        .VLEN       (VLEN),
        .PIPE_WIDTH (PIPE_WIDTH),
        .CNT_W      (CNT_W)
    ) u_beat_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .lmul_i     (lmul_i),
        .last_o     (cnt_last),
        .reserved_o (lmul_rsvd)
    );

    // Lowest selected source, and the next selected source after the current one.
    always_comb begin
        first_src = '0;
        has_src   = 1'b0;
        next_src  = '0;
        has_next  = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (sel_q[k]) begin
                first_src = SW'(k);
                has_src   = 1'b1;
                if (k > int'(src_q)) begin
                    next_src = SW'(k);
                    has_next = 1'b1;
                end
            end
        end
    end

    assign mem_err = data_err_i | data_pmp_err_i;

    // Next-state and output decode; req_i is gated by reset so outputs stay low in reset.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        src_d         = src_q;
        wgnt_d        = wgnt_q;
        agu_load_o    = 1'b0;
        agu_get_o     = '0;
        data_req_o    = 1'b0;
        data_we_o     = 1'b0;
        rvalid_o      = 1'b0;
        wready_o      = 1'b0;
        vector_done_o = 1'b0;
        err_o         = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        cap_en        = 1'b0;
        wcap          = 1'b0;
        beat_end      = 1'b0;
        unique case (state_q)
            VRF_IDLE: begin
                if (req_i && rst_ni) begin
                    if (lmul_rsvd) begin
                        err_o = 1'b1;
                    end else begin
                        agu_load_o = 1'b1;
                        cnt_load   = 1'b1;
                        sel_d      = sel_operation_i;
                        state_d    = VRF_LOAD;
                    end
                end
            end
            VRF_LOAD: begin
                if (agu_ready_i) begin
                    if (sel_q == '0) begin
                        state_d = VRF_IDLE;
                    end else if (has_src) begin
                        src_d   = first_src;
                        state_d = VRF_REQ;
                    end else begin
                        state_d = VRF_WRITE;
                    end
                end
            end
            VRF_REQ: begin
                data_req_o = 1'b1;
                if (data_gnt_i) begin
                    agu_get_o = (NUM_SRC+1)'(1) << src_q;
                    state_d   = VRF_WAIT;
                end
            end
            VRF_WAIT: begin
                if (data_rvalid_i) begin
                    if (mem_err) begin
                        err_o   = 1'b1;
                        state_d = VRF_IDLE;
                    end else begin
                        cap_en = 1'b1;
                        if (has_next) begin
                            src_d   = next_src;
                            state_d = VRF_REQ;
                        end else begin
                            state_d = VRF_PRESENT;
                        end
                    end
                end
            end
            VRF_PRESENT: begin
                rvalid_o = 1'b1;
                if (rready_i) begin
                    if (sel_q[NUM_SRC]) begin
                        state_d = VRF_WRITE;
                    end else begin
                        beat_end = 1'b1;
                    end
                end
            end
            VRF_WRITE: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    wcap    = 1'b1;
                    wgnt_d  = 1'b0;
                    state_d = VRF_WWAIT;
                end
            end
            VRF_WWAIT: begin
                if (!wgnt_q) begin
                    data_req_o = 1'b1;
                    data_we_o  = 1'b1;
                    if (data_gnt_i) begin
                        agu_get_o[NUM_SRC] = 1'b1;
                        wgnt_d             = 1'b1;
                    end
                end else if (data_rvalid_i) begin
                    if (mem_err) begin
                        err_o   = 1'b1;
                        state_d = VRF_IDLE;
                    end else begin
                        beat_end = 1'b1;
                    end
                end
            end
            default: state_d = VRF_IDLE;
        endcase
        if (beat_end) begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
                vector_done_o = 1'b1;
                state_d       = VRF_IDLE;
            end else if (has_src) begin
                src_d   = first_src;
                state_d = VRF_REQ;
            end else begin
                state_d = VRF_WRITE;
            end
        end
    end

    // State, operand and write-data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= VRF_IDLE;
            sel_q   <= '0;
            src_q   <= '0;
            wgnt_q  <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            src_q   <= src_d;
            wgnt_q  <= wgnt_d;
            if (cap_en) begin
                rdata_q[int'(src_q)*PIPE_WIDTH +: PIPE_WIDTH] <= data_rdata_i;
            end
            if (wcap) begin
                wdata_q <= wdata_i;
            end
        end
    end

    assign busy_o       = (state_q != VRF_IDLE);
    assign rdata_o      = rdata_q;
    assign data_wdata_o = wdata_q;
    assign data_be_o    = {(PIPE_WIDTH/8){rst_ni}};

endmodule

// File: tb/tb_vcve2_vrf_sequencer.sv
// Randomized bench for vcve2_vrf_sequencer against a transaction-level
// model: an expected queue of reads, presentations and writes per operation.
module tb_vcve2_vrf_sequencer;
    import vcve2_pkg::*;

    localparam int VLEN = 128;
    localparam int PW   = 32;
    localparam int NS   = 3;
    localparam int BASE = VLEN / PW;
    localparam int WR   = NS;
    localparam int PRES = NS + 1;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic req_i = 1'b0;
    logic [NS:0] sel_operation_i = '0;
    vlmul_e lmul_i = LMUL_1;
    logic busy_o;
    logic [NS*PW-1:0] rdata_o;
    logic rvalid_o;
    logic rready_i = 1'b0;
    logic [PW-1:0] wdata_i = '0;
    logic wvalid_i = 1'b0;
    logic wready_o;
    logic data_req_o, data_we_o;
    logic data_gnt_i = 1'b0;
    logic data_rvalid_i = 1'b0;
    logic data_err_i = 1'b0;
    logic data_pmp_err_i = 1'b0;
    logic [PW/8-1:0] data_be_o;
    logic [PW-1:0] data_wdata_o;
    logic [PW-1:0] data_rdata_i = '0;
    logic agu_load_o;
    logic [NS:0] agu_get_o;
    logic agu_ready_i = 1'b0;
    logic vector_done_o, err_o;

    always #5 clk = ~clk;

    vcve2_vrf_sequencer #(.VLEN(VLEN), .PIPE_WIDTH(PW), .NUM_SRC(NS)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i),
        .sel_operation_i(sel_operation_i), .lmul_i(lmul_i),
        .busy_o(busy_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i),
        .wready_o(wready_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i), .data_pmp_err_i(data_pmp_err_i),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i), .agu_load_o(agu_load_o),
        .agu_get_o(agu_get_o), .agu_ready_i(agu_ready_i),
        .vector_done_o(vector_done_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_fail = 0;

    int q[$];
    bit m_busy, m_load, m_zero, w_acc;
    int outst, cur_src;
    bit cur_we;
    logic [NS:0] sel_m;
    logic [PW-1:0] slice [NS];
    logic [PW-1:0] wdata_exp;
    int rd_g, wr_g, pres_n, done_n, err_n;
    bit p_req, p_gnt, p_we, p_rv, p_rr;
    logic [NS*PW-1:0] p_rdata;
    bit gnt_evt;
    int req_cnt, rvw, rv_cnt;
    int mode;
    bit inj_arm, rand_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 1 expected 0", name);
    endtask

    function automatic int beats_of(input int l);
        int b;
        if (l >= 0) b = BASE * (1 << l);
        else b = BASE / (1 << (-l));
        if (b < 1) b = 1;
        return b;
    endfunction

    // Compare process: at each falling edge check outputs against the model, then advance it.
    initial begin
        int head, nb, l;
        bit acc, rsv, ev, err_now, exp_done;
        logic [2:0] lr;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                q.delete();
                m_busy = 0; m_load = 0; m_zero = 0; w_acc = 0; outst = 0;
                p_req = 0; p_gnt = 0; p_rv = 0; p_rr = 0; p_we = 0;
                req_cnt = 0; rvw = 0;
                continue;
            end
            head = (q.size() > 0) ? q[0] : -1;
            chk("busy", busy_o, m_busy);
            chk("data_req", data_req_o, m_busy && !m_load && outst == 0 &&
                ((head >= 0 && head < NS) || (head == WR && w_acc)));
            chk("rvalid", rvalid_o, m_busy && !m_load && outst == 0 && head == PRES);
            chk("wready", wready_o, m_busy && !m_load && outst == 0 && head == WR && !w_acc);
            if (p_req && !p_gnt) chk("req_hold", {data_req_o, data_we_o}, {1'b1, p_we});
            if (p_rv && !p_rr) chk("rdata_hold", rdata_o, p_rdata);
            acc = req_i && !busy_o;
            rsv = (lmul_i == LMUL_RSVD);
            chk("agu_load", agu_load_o, acc && !rsv);
            ev = 0;
            err_now = 0;
            if (data_rvalid_i && outst > 0) begin
                ev = 1;
                outst = 0;
                if (data_err_i || data_pmp_err_i) err_now = 1;
                else if (!cur_we) slice[cur_src] = data_rdata_i;
            end
            if (data_req_o && data_gnt_i) begin
                gnt_evt = 1;
                chk("be", data_be_o, {(PW/8){1'b1}});
                if (head >= 0 && head < NS) begin
                    chk("rd_we", data_we_o, 0);
                    chk("rd_get", agu_get_o, 1 << head);
                    cur_src = head; cur_we = 0; rd_g++;
                end else if (head == WR) begin
                    chk("wr_we", data_we_o, 1);
                    chk("wr_get", agu_get_o, 1 << NS);
                    chk("wr_data", data_wdata_o, wdata_exp);
                    cur_we = 1; wr_g++; w_acc = 0;
                end else begin
                    flag("spurious_grant");
                end
                if (q.size() > 0) void'(q.pop_front());
                outst = 1;
            end else begin
                chk("get_idle", agu_get_o, 0);
            end
            if (wready_o && wvalid_i) begin
                w_acc = 1;
                wdata_exp = wdata_i;
            end
            if (rvalid_o && rready_i && q.size() > 0 && q[0] == PRES) begin
                for (int k = 0; k < NS; k++)
                    if (sel_m[k]) chk($sformatf("rdata_s%0d", k), rdata_o[k*PW +: PW], slice[k]);
                void'(q.pop_front());
                pres_n++;
                ev = 1;
            end
            exp_done = m_busy && ev && !err_now && q.size() == 0 && outst == 0;
            chk("done", vector_done_o, exp_done);
            chk("err", err_o, (acc && rsv) || err_now);
            done_n += int'(vector_done_o);
            err_n += int'(err_o);
            if (err_now || exp_done) begin
                m_busy = 0; q.delete(); w_acc = 0; outst = 0;
            end
            if (m_busy && m_load && agu_ready_i) begin
                m_load = 0;
                if (m_zero) m_busy = 0;
            end
            if (acc && !rsv) begin
                m_busy = 1; m_load = 1; w_acc = 0;
                sel_m = sel_operation_i;
                m_zero = (sel_operation_i == '0);
                lr = lmul_i;
                l = $signed(lr);
                nb = beats_of(l);
                q.delete();
                for (int b = 0; b < nb; b++) begin
                    for (int k = 0; k < NS; k++) if (sel_m[k]) q.push_back(k);
                    if (sel_m[NS-1:0] != '0) q.push_back(PRES);
                    if (sel_m[NS]) q.push_back(WR);
                end
            end
            if (data_req_o && !data_gnt_i) req_cnt++; else req_cnt = 0;
            if (rvalid_o && !rready_i) rvw++; else rvw = 0;
            p_req = data_req_o; p_gnt = data_gnt_i; p_we = data_we_o;
            p_rv = rvalid_o; p_rr = rready_i; p_rdata = rdata_o;
        end
    end

    // Memory, AGU and pipeline responder, driven just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_ni) begin
                rv_cnt = 0; gnt_evt = 0;
                data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_pmp_err_i = 0;
                rready_i = 0; wvalid_i = 0; agu_ready_i = 0;
                continue;
            end
            if (gnt_evt) begin
                gnt_evt = 0;
                rv_cnt = (mode == 0) ? int'($urandom_range(1, 3)) : 1;
            end
            data_rvalid_i = 0;
            data_pmp_err_i = 0;
            data_err_i = (mode == 0) && ($urandom_range(0, 7) == 0);
            data_rdata_i = $urandom;
            wdata_i = $urandom;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    data_rvalid_i = 1;
                    data_err_i = 0;
                    if (inj_arm && pres_n == 1) begin
                        data_pmp_err_i = 1;
                        inj_arm = 0;
                    end else if (mode == 0 && rand_err && $urandom_range(0, 63) == 0) begin
                        data_err_i = 1;
                    end
                end
            end
            case (mode)
                1: begin
                    data_gnt_i = 1; rready_i = 1; wvalid_i = 1; agu_ready_i = 1;
                end
                2: begin
                    data_gnt_i = (req_cnt >= 3); rready_i = (rvw >= 2);
                    wvalid_i = 1; agu_ready_i = 1;
                end
                default: begin
                    data_gnt_i = ($urandom_range(0, 3) != 0);
                    rready_i = ($urandom_range(0, 2) != 0);
                    wvalid_i = ($urandom_range(0, 2) != 0);
                    agu_ready_i = ($urandom_range(0, 3) != 0);
                end
            endcase
        end
    end

    task automatic clear_counts();
        rd_g = 0; wr_g = 0; pres_n = 0; done_n = 0; err_n = 0;
    endtask

    task automatic run_op(input logic [2:0] l, input logic [NS:0] s);
        int c;
        clear_counts();
        @(posedge clk);
        #2;
        lmul_i = vlmul_e'(l);
        sel_operation_i = s;
        req_i = 1;
        @(posedge clk);
        #2;
        req_i = 0;
        c = 0;
        while (m_busy && c < 5000) begin
            @(posedge clk);
            c++;
        end
        if (m_busy) flag("op_timeout");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {busy_o, rvalid_o, wready_o, data_req_o, data_we_o,
                            agu_load_o, vector_done_o, err_o}, 0);
        chk({tag, "_rdata"}, rdata_o, 0);
        chk({tag, "_wdata"}, data_wdata_o, 0);
        chk({tag, "_be"}, data_be_o, 0);
        chk({tag, "_get"}, agu_get_o, 0);
    endtask

    initial begin
        int c;
        logic [2:0] l;
        logic [NS:0] s;
        bit rs;
        mode = 1;
        inj_arm = 0;
        rand_err = 0;
        req_i = 1;
        sel_operation_i = 4'b1111;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        req_i = 0;
        @(posedge clk);
        #3;
        rst_ni = 1;

        run_op(3'b000, 4'b1011);
        chk("m1_pres", pres_n, 4);
        chk("m1_rd", rd_g, 8);
        chk("m1_wr", wr_g, 4);
        chk("m1_gnts", rd_g + wr_g, 12);
        chk("m1_done", done_n, 1);

        run_op(3'b001, 4'b0001);
        chk("m2_pres", pres_n, 8);
        chk("m2_rd", rd_g, 8);
        chk("m2_done", done_n, 1);

        run_op(3'b101, 4'b0011);
        chk("mf8_pres", pres_n, 1);
        chk("mf8_done", done_n, 1);

        mode = 2;
        run_op(3'b000, 4'b1111);
        chk("slow_rd", rd_g, 12);
        chk("slow_wr", wr_g, 4);
        chk("slow_done", done_n, 1);

        inj_arm = 1;
        run_op(3'b000, 4'b0011);
        inj_arm = 0;
        chk("pmp_err", err_n, 1);
        chk("pmp_nodone", done_n, 0);
        chk("pmp_pres", pres_n, 1);

        mode = 1;
        run_op(3'b100, 4'b0011);
        chk("rsv_err", err_n, 1);
        chk("rsv_traffic", rd_g + wr_g, 0);

        run_op(3'b000, 4'b0000);
        chk("sel0_pulses", done_n + err_n, 0);

        mode = 2;
        clear_counts();
        @(posedge clk);
        #2;
        lmul_i = LMUL_1;
        sel_operation_i = 4'b1000;
        req_i = 1;
        @(posedge clk);
        #2;
        req_i = 0;
        c = 0;
        while (!(data_req_o && data_we_o) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!(data_req_o && data_we_o)) flag("wwait_timeout");
        #2;
        rst_ni = 0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #3;
        rst_ni = 1;
        chk("midrst_pulses", done_n + err_n, 0);
        mode = 1;
        run_op(3'b000, 4'b1011);
        chk("post_rst_done", done_n, 1);
        chk("post_rst_pres", pres_n, 4);

        mode = 0;
        rand_err = 1;
        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 15);
            if (c == 0) l = 3'b100;
            else begin
                l = 3'($urandom_range(0, 7));
                if (l == 3'b100) l = 3'b000;
            end
            s = 4'($urandom_range(0, 15));
            rs = (l == 3'b100);
            run_op(l, s);
            chk("rand_pulses", done_n + err_n, (rs || s != '0) ? 1 : 0);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
